// File: rtl/i2s_rx_stream_if.sv
// i2s_rx_stream_if
//   Stereo sample stream from the I2S receiver to the DSP pipeline.
//   out_left/out_right : head stereo frame, meaningful while out_valid
//   out_valid          : a frame is available
//   out_ready          : consumer takes the head frame when out_valid && out_ready
//   master : the receiver (drives data/valid)
//   slave  : the consumer (drives ready)
interface i2s_rx_stream_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] out_left;
  logic [DATA_W-1:0] out_right;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_left, output out_right, output out_valid, input out_ready);
  modport slave  (input out_left, input out_right, input out_valid, output out_ready);
endinterface

// File: rtl/i2s_rx_stream.sv
// i2s_rx_stream
//   I2S master receiver for a PCM1808 front end. A single frame counter in the
//   clk domain produces BCK/LRCK; din is sampled on BCK rise cycles with the
//   I2S one-BCK delay, and finished stereo frames go through a small
//   first-word-fall-through FIFO onto a valid/ready stream.
//
// Ports
//   clk, reset : system clock, synchronous active-high reset
//   en         : receiver enable; low parks the clock generator at frame start
//   din        : PCM1808 DOUT
//   scki       : system clock forwarded to the ADC
//   bck, lrck  : bit clock / frame clock (low = left slot), register bits
//   strm       : stream master (out_left, out_right, out_valid, out_ready)
//   overflow   : sticky, a frame was dropped on a full FIFO
//   drop_count : dropped-frame counter, saturating (only with I2S_RX_DROP_CNT_EN)
//
// Build option
//   I2S_RX_DROP_CNT_EN : adds drop_count[15:0].
module i2s_rx_stream #(
  parameter int DATA_W     = 24,
  parameter int SLOT_W     = 32,
  parameter int BCK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               din,
  output logic               scki,
  output logic               bck,
  output logic               lrck,
  i2s_rx_stream_if.master    strm,
  output logic               overflow
`ifdef I2S_RX_DROP_CNT_EN
  ,
  output logic [15:0]        drop_count
`endif
);

  localparam int PH_W   = $clog2(BCK_DIV);
  localparam int B_W    = $clog2(SLOT_W);
  localparam int FCNT_W = PH_W + B_W + 1;
  localparam int AW     = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } frame_t;

  // ---------------------------------------------------------------- timing
  logic [FCNT_W-1:0] r_fcnt;
  logic [PH_W-1:0]   w_phase;
  logic [B_W-1:0]    w_bidx;
  logic              w_lr;
  logic              w_cap;
  logic              w_last;

  assign w_phase = r_fcnt[PH_W-1:0];
  assign w_bidx  = r_fcnt[PH_W +: B_W];
  assign w_lr    = r_fcnt[FCNT_W-1];

  // bck high for the upper half of the phase range is just the phase MSB,
  // so both clocks come straight off counter flops (glitch free).
  assign scki = clk;
  assign bck  = r_fcnt[PH_W-1];
  assign lrck = w_lr;

  // Bit 0 of each slot is the I2S delay bit; data sits in b = 1..DATA_W.
  assign w_cap  = (w_phase == PH_W'(BCK_DIV/2)) && (w_bidx != '0) &&
                  (w_bidx <= B_W'(DATA_W));
  assign w_last = w_cap && w_lr && (w_bidx == B_W'(DATA_W));

  logic [DATA_W-1:0] r_sh_l, r_sh_r;
  logic              r_push;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      r_fcnt <= '0;
      r_sh_l <= '0;
      r_sh_r <= '0;
      r_push <= 1'b0;
    end else begin
      r_fcnt <= r_fcnt + FCNT_W'(1);
      r_push <= w_last;
      if (w_cap && !w_lr) r_sh_l <= {r_sh_l[DATA_W-2:0], din};
      if (w_cap &&  w_lr) r_sh_r <= {r_sh_r[DATA_W-2:0], din};
    end
  end

  // ------------------------------------------------------------------ FIFO
  frame_t [FIFO_DEPTH-1:0] r_mem;
  logic [AW:0]             r_wptr, r_rptr;
  logic                    w_empty, w_full, w_pop, w_push, w_wr, w_drop;

  // A frame finishing exactly as reset/disable arrives is discarded.
  assign w_push  = r_push && en && !reset;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = ((r_wptr ^ r_rptr) == {1'b1, {AW{1'b0}}});
  assign w_pop   = !w_empty && strm.out_ready;
  // When full, a same-cycle pop frees the slot being written (wptr and rptr
  // share their low bits), so the write lands on the entry just consumed.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= '{l: r_sh_l, r: r_sh_r};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_wr)   r_wptr   <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr   <= r_rptr + (AW+1)'(1);
      if (w_drop) overflow <= 1'b1;
    end
  end

`ifdef I2S_RX_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                              drop_count <= '0;
    else if (w_drop && drop_count != '1)    drop_count <= drop_count + 16'd1;
  end
`endif

  // Data reads as zero while empty so nothing stale shows after reset.
  assign strm.out_valid = !w_empty;
  assign strm.out_left  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]].l;
  assign strm.out_right = w_empty ? '0 : r_mem[r_rptr[AW-1:0]].r;

endmodule

// File: tb/tb_i2s_rx_stream.sv
// tb_i2s_rx_stream
//   Bench for i2s_rx_stream: a default instance (24/32/4/4) and a narrow one
//   (DATA_W=16, SLOT_W=32, BCK_DIV=2). A PCM1808-like source per instance
//   follows bck/lrck and shifts words out MSB-first one BCK after each LRCK
//   edge, padding unused bit slots with 1. Left/right words of frame n in
//   the default instance are A5A5A5/5A5A5A with n xor-ed into the top byte;
//   the narrow instance always sends 8001 on both channels.
module tb_i2s_rx_stream;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic din0 = 1'b1, din1 = 1'b1;
  logic rdy0 = 1'b1, rdy1 = 1'b1;
  logic scki0, bck0, lrck0, ovf0;
  logic scki1, bck1, lrck1, ovf1;
`ifdef I2S_RX_DROP_CNT_EN
  logic [15:0] dcnt0, dcnt1;
`endif

  always #5 clk = ~clk;

  i2s_rx_stream_if #(.DATA_W(24)) s0 ();
  i2s_rx_stream_if #(.DATA_W(16)) s1 ();
  assign s0.out_ready = rdy0;
  assign s1.out_ready = rdy1;

  i2s_rx_stream #(.DATA_W(24), .SLOT_W(32), .BCK_DIV(4), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .en(en), .din(din0), .scki(scki0), .bck(bck0),
    .lrck(lrck0), .strm(s0), .overflow(ovf0)
`ifdef I2S_RX_DROP_CNT_EN
    , .drop_count(dcnt0)
`endif
  );

  i2s_rx_stream #(.DATA_W(16), .SLOT_W(32), .BCK_DIV(2), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .en(en), .din(din1), .scki(scki1), .bck(bck1),
    .lrck(lrck1), .strm(s1), .overflow(ovf1)
`ifdef I2S_RX_DROP_CNT_EN
    , .drop_count(dcnt1)
`endif
  );

  int n_chk = 0, n_fail = 0, cyc = 0;

  function automatic logic [23:0] exp_l(input int n);
    return 24'hA5A5A5 ^ {n[7:0], 16'h0000};
  endfunction
  function automatic logic [23:0] exp_r(input int n);
    return 24'h5A5A5A ^ {n[7:0], 16'h0000};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); cyc++; end
  endtask
  task automatic goto(input int t);
    while (cyc < t) tick(1);
  endtask

  // ------------------------------------------------------------ ADC model
  int   adc_k[2], adc_fn[2];
  logic adc_pl[2], adc_pb[2];

  task automatic adc_step(input int i, input logic b, input logic l, output logic d);
    logic [23:0] w;
    int dw;
    if (reset || !en) begin
      adc_k[i] = 0; adc_fn[i] = 0; adc_pl[i] = 1'b0; adc_pb[i] = 1'b0;
    end else begin
      if (l != adc_pl[i]) begin
        adc_k[i] = 0;
        if (!l) adc_fn[i]++;
      end else if (adc_pb[i] && !b) adc_k[i]++;
      adc_pl[i] = l;
      adc_pb[i] = b;
    end
    dw = (i == 1) ? 16 : 24;
    w  = (i == 1) ? 24'h008001 : (l ? exp_r(adc_fn[i]) : exp_l(adc_fn[i]));
    d  = (adc_k[i] >= 1 && adc_k[i] <= dw) ? w[dw - adc_k[i]] : 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      adc_step(0, bck0, lrck0, din0);
      adc_step(1, bck1, lrck1, din1);
    end
  end

  // ---------------------------------------------------------------- vectors
  typedef struct {
    int          cyc;
    int          inst;
    logic        bck;
    logic        lrck;
    logic        vld;
    logic [23:0] l;
    logic [23:0] r;
  } vec_t;
  vec_t tbl[$];

  initial begin
    tbl.push_back('{0,   0, 0, 0, 0, 24'h0, 24'h0});
    tbl.push_back('{0,   1, 0, 0, 0, 24'h0, 24'h0});
    tbl.push_back('{1,   1, 1, 0, 0, 24'h0, 24'h0});
    tbl.push_back('{2,   0, 1, 0, 0, 24'h0, 24'h0});
    tbl.push_back('{2,   1, 0, 0, 0, 24'h0, 24'h0});
    tbl.push_back('{3,   0, 1, 0, 0, 24'h0, 24'h0});
    tbl.push_back('{4,   0, 0, 0, 0, 24'h0, 24'h0});
    tbl.push_back('{64,  1, 0, 1, 0, 24'h0, 24'h0});
    tbl.push_back('{97,  1, 1, 1, 0, 24'h0, 24'h0});
    tbl.push_back('{98,  1, 0, 1, 0, 24'h0, 24'h0});
    tbl.push_back('{99,  1, 1, 1, 1, 24'h008001, 24'h008001});
    tbl.push_back('{100, 1, 0, 1, 0, 24'h0, 24'h0});
    tbl.push_back('{127, 0, 1, 0, 0, 24'h0, 24'h0});
    tbl.push_back('{128, 0, 0, 1, 0, 24'h0, 24'h0});
    tbl.push_back('{128, 1, 0, 0, 0, 24'h0, 24'h0});
    tbl.push_back('{130, 0, 1, 1, 0, 24'h0, 24'h0});
    tbl.push_back('{226, 0, 1, 1, 0, 24'h0, 24'h0});
    tbl.push_back('{227, 0, 1, 1, 0, 24'h0, 24'h0});
    tbl.push_back('{227, 1, 1, 1, 1, 24'h008001, 24'h008001});
    tbl.push_back('{228, 0, 0, 1, 1, 24'hA5A5A5, 24'h5A5A5A});
    tbl.push_back('{229, 0, 0, 1, 0, 24'h0, 24'h0});
    tbl.push_back('{255, 0, 1, 1, 0, 24'h0, 24'h0});
    tbl.push_back('{256, 0, 0, 0, 0, 24'h0, 24'h0});
    tbl.push_back('{484, 0, 0, 1, 1, exp_l(1), exp_r(1)});
    tbl.push_back('{485, 0, 0, 1, 0, 24'h0, 24'h0});

    // Reset values, then idle with en low.
    tick(3);
    chk("rst bck", bck0, 0);
    chk("rst lrck", lrck0, 0);
    chk("rst valid", s0.out_valid, 0);
    chk("rst overflow", ovf0, 0);
    chk("rst left", s0.out_left, 0);
    chk("rst right", s0.out_right, 0);
    reset = 1'b0;
    tick(5);
    chk("idle bck", bck0, 0);
    chk("idle valid", s0.out_valid, 0);
    chk("idle small valid", s1.out_valid, 0);

    // Enable: fcnt is 0 on this cycle, so cyc tracks fcnt from here.
    en = 1'b1;
    cyc = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      goto(tbl[i].cyc);
      if (tbl[i].inst == 0) begin
        chk($sformatf("v%0d bck", i), bck0, tbl[i].bck);
        chk($sformatf("v%0d lrck", i), lrck0, tbl[i].lrck);
        chk($sformatf("v%0d valid", i), s0.out_valid, tbl[i].vld);
        if (tbl[i].vld) begin
          chk($sformatf("v%0d left", i), s0.out_left, tbl[i].l);
          chk($sformatf("v%0d right", i), s0.out_right, tbl[i].r);
        end
      end else begin
        chk($sformatf("v%0d small bck", i), bck1, tbl[i].bck);
        chk($sformatf("v%0d small lrck", i), lrck1, tbl[i].lrck);
        chk($sformatf("v%0d small valid", i), s1.out_valid, tbl[i].vld);
        if (tbl[i].vld) begin
          chk($sformatf("v%0d small left", i), s1.out_left, tbl[i].l[15:0]);
          chk($sformatf("v%0d small right", i), s1.out_right, tbl[i].r[15:0]);
        end
      end
    end

    // Overflow: consumer stalled for 6 frames.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    rdy0 = 1'b0;
    cyc = 0;
    goto(228 + 256*3);
    chk("ovf 4 held valid", s0.out_valid, 1);
    chk("ovf 4 held overflow", ovf0, 0);
    chk("ovf head left", s0.out_left, exp_l(0));
    goto(228 + 256*4);
    chk("ovf after frame 5", ovf0, 1);
`ifdef I2S_RX_DROP_CNT_EN
    chk("drop_count 1", dcnt0, 1);
`endif
    goto(228 + 256*5);
    chk("ovf sticky", ovf0, 1);
`ifdef I2S_RX_DROP_CNT_EN
    chk("drop_count 2", dcnt0, 2);
`endif
    goto(1510);
    rdy0 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("drain%0d valid", n), s0.out_valid, 1);
      chk($sformatf("drain%0d left", n), s0.out_left, exp_l(n));
      chk($sformatf("drain%0d right", n), s0.out_right, exp_r(n));
      tick(1);
    end
    chk("drain empty", s0.out_valid, 0);

    // Reset in the middle of a left slot (fcnt=100), held 3 cycles.
    goto(1536 + 100);
    reset = 1'b1;
    tick(1);
    chk("midrst bck", bck0, 0);
    chk("midrst lrck", lrck0, 0);
    chk("midrst valid", s0.out_valid, 0);
    chk("midrst overflow", ovf0, 0);
`ifdef I2S_RX_DROP_CNT_EN
    chk("midrst drop_count", dcnt0, 0);
`endif
    tick(2);
    reset = 1'b0;
    rdy0 = 1'b0;
    cyc = 0;

    // Full FIFO with ready pulsed only in the push cycle of frame 5.
    goto(228 + 256*3);
    chk("full valid", s0.out_valid, 1);
    chk("full head left", s0.out_left, exp_l(0));
    chk("full head right", s0.out_right, exp_r(0));
    goto(228 + 256*4 - 1);
    rdy0 = 1'b1;
    tick(1);
    rdy0 = 1'b0;
    chk("pushpop overflow", ovf0, 0);
`ifdef I2S_RX_DROP_CNT_EN
    chk("pushpop drop_count", dcnt0, 0);
`endif
    rdy0 = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      chk($sformatf("pp%0d valid", n), s0.out_valid, 1);
      chk($sformatf("pp%0d left", n), s0.out_left, exp_l(n));
      chk($sformatf("pp%0d right", n), s0.out_right, exp_r(n));
      tick(1);
    end
    chk("pp empty", s0.out_valid, 0);
    chk("pp overflow end", ovf0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
